// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory port arbiter.
//   state_t        : arbiter FSM state (ST_IDLE, ST_BUSY)
//   OWN_*          : encoding of the current transaction owner (dbg_owner)
//   STARVE_MAX_DEF : default number of consecutive data grants while fetch waits
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arb_watchdog
// Counts BUSY cycles of an outstanding memory transaction and flags expiry.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-low reset
//   i_count_en : transaction outstanding and past its mem_en cycle
//   i_ack      : qualified memory completion (wins over expiry)
//   o_expire   : 1-cycle expiry indication, ends the transaction
//   o_err      : sticky error, cleared only by reset
// -----------------------------------------------------------------------------
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_count_en,
  input  logic i_ack,
  output logic o_expire,
  output logic o_err
);

  // Counter holds the number of already-completed counting cycles, so the
  // TIMEOUT_CYC-th counting cycle is the one where it reads TIMEOUT_CYC-1.
  localparam logic [4:0] LIMIT = 5'(TIMEOUT_CYC - 1);

  logic [4:0] r_cnt;
  logic       r_err;

  assign o_expire = i_count_en && !i_ack && (r_cnt == LIMIT);
  assign o_err    = r_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_count_en && !i_ack && !o_expire) begin
        r_cnt <= r_cnt + 5'd1;
      end else begin
        r_cnt <= '0;
      end
      if (o_expire) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (if_*) and load/store (d_*).
// One transaction at a time; data has priority, but after STARVE_MAX
// consecutive data grants with fetch waiting, fetch wins the next arbitration.
//
// Handshake: a requester raises req with stable addr/wdata and holds them
// until the 1-cycle gnt pulse. The response is a 1-cycle rvalid pulse with
// rdata, which then holds until that requester's next response. A req still
// high after gnt is a new request. Memory side: mem_en pulses once per
// transaction, mem_we/addr/wdata hold through BUSY, and mem_ack (latency >= 1)
// completes it; mem_ack in IDLE or in the mem_en cycle is ignored.
//
// Ports:
//   clk, reset                      : clock, synchronous active-low reset
//   if_req/if_addr                  : fetch request
//   if_gnt/if_rvalid/if_rdata       : fetch grant and response
//   d_req/d_we/d_addr/d_wdata       : data request (d_we=1 store)
//   d_gnt/d_rvalid/d_rdata          : data grant and response/store ack
//   mem_en/mem_we/mem_addr/mem_wdata: memory request
//   mem_ack/mem_rdata               : memory completion
//   dbg_owner                       : 0 none, 1 fetch, 2 data (FSM visibility)
//   timeout_err                     : sticky watchdog error
//
// Configuration: define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog
// (TIMEOUT_CYC cycles); otherwise BUSY waits indefinitely and timeout_err=0.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = STARVE_MAX_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_owner,
  output logic              timeout_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            r_state;
  logic [1:0]        r_owner;
  logic [3:0]        r_starve_cnt;
  logic              r_if_gnt;
  logic              r_d_gnt;
  logic              r_if_rvalid;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_any_req;
  logic              w_if_wins;
  logic              w_ack;
  logic              w_expire;
  logic              w_err;
  logic              w_done;
  logic [DATA_W-1:0] w_resp_data;

  assign w_any_req = if_req | d_req;
  // Only meaningful when w_any_req: fetch wins when data is absent or starved.
  assign w_if_wins = !d_req || (if_req && (r_starve_cnt == STARVE_LIM));
  // The mem_en cycle cannot carry the completion of its own request.
  assign w_ack     = (r_state == ST_BUSY) && !r_mem_en && mem_ack;
  assign w_done    = w_ack || w_expire;
  // An expired transaction returns zero data.
  assign w_resp_data = w_ack ? mem_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  logic w_count_en;
  assign w_count_en = (r_state == ST_BUSY) && !r_mem_en;

  mem_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_count_en (w_count_en),
    .i_ack      (w_ack),
    .o_expire   (w_expire),
    .o_err      (w_err)
  );
`else
  assign w_expire = 1'b0;
  // Watchdog absent: the error flag is the constant 0 (expression below is
  // always false for any legal TIMEOUT_CYC).
  assign w_err    = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
      r_if_gnt     <= 1'b0;
      r_d_gnt      <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      // Pulse outputs default low.
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_mem_en    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state  <= ST_BUSY;
            r_mem_en <= 1'b1;
            if (w_if_wins) begin
              r_owner      <= OWN_IF;
              r_if_gnt     <= 1'b1;
              r_mem_we     <= 1'b0;
              r_mem_addr   <= if_addr;
              r_mem_wdata  <= '0;
              r_starve_cnt <= '0;
            end else begin
              r_owner     <= OWN_D;
              r_d_gnt     <= 1'b1;
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
              if (!if_req) begin
                r_starve_cnt <= '0;
              end else if (r_starve_cnt < STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
              end
            end
          end
        end
        ST_BUSY: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
            if (r_owner == OWN_IF) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= w_resp_data;
            end else begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= w_resp_data;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_gnt      = r_if_gnt;
  assign if_rvalid   = r_if_rvalid;
  assign if_rdata    = r_if_rdata;
  assign d_gnt       = r_d_gnt;
  assign d_rvalid    = r_d_rvalid;
  assign d_rdata     = r_d_rdata;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign dbg_owner   = r_owner;
  assign timeout_err = w_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Each scenario task drives its stimulus
// and checks the outputs inline. Inputs change and outputs are sampled 1 time
// unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    dbg_owner;
  logic          timeout_err;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_MAX  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .dbg_owner   (dbg_owner),
    .timeout_err (timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a completion in the current cycle; returns in the response cycle.
  task automatic mem_respond(input logic [DW-1:0] data);
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_vec++; if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we} !== 6'b0) begin n_err++; $display("FAIL reset_pulses: got %b want 000000", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}); end
    n_vec++; if (dbg_owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", dbg_owner); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    n_vec++; if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {if_rdata, d_rdata, mem_addr, mem_wdata}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req  = 1'b1;
    if_addr = 32'h40;
    tick();  // N+1
    n_vec++; if ({if_gnt, d_gnt, mem_en} !== 3'b101) begin n_err++; $display("FAIL fetch_gnt: got %b want 101", {if_gnt, d_gnt, mem_en}); end
    n_vec++; if (mem_addr !== 32'h40) begin n_err++; $display("FAIL fetch_addr: got %h want 00000040", mem_addr); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_we: got %b want 0", mem_we); end
    n_vec++; if (dbg_owner !== 2'd1) begin n_err++; $display("FAIL fetch_owner_busy: got %0d want 1", dbg_owner); end
    if_req = 1'b0;
    tick();  // N+2
    n_vec++; if ({if_gnt, mem_en, if_rvalid} !== 3'b000) begin n_err++; $display("FAIL fetch_wait: got %b want 000", {if_gnt, mem_en, if_rvalid}); end
    tick();  // N+3 = M, two cycles after mem_en
    mem_respond(32'h2402000A);  // M+1
    n_vec++; if ({if_rvalid, d_rvalid} !== 2'b10) begin n_err++; $display("FAIL fetch_rvalid: got %b want 10", {if_rvalid, d_rvalid}); end
    n_vec++; if (if_rdata !== 32'h2402000A) begin n_err++; $display("FAIL fetch_rdata: got %h want 2402000a", if_rdata); end
    n_vec++; if (dbg_owner !== 2'd0) begin n_err++; $display("FAIL fetch_owner_idle: got %0d want 0", dbg_owner); end
    tick();
    n_vec++; if (if_rvalid !== 1'b0) begin n_err++; $display("FAIL fetch_rvalid_pulse: got %b want 0", if_rvalid); end
    n_vec++; if (if_rdata !== 32'h2402000A) begin n_err++; $display("FAIL fetch_rdata_hold: got %h want 2402000a", if_rdata); end
  endtask

  task automatic test_conflict();
    if_req  = 1'b1;
    if_addr = 32'h44;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h100;
    tick();  // N+1
    n_vec++; if ({d_gnt, if_gnt} !== 2'b10) begin n_err++; $display("FAIL conflict_first_gnt: got %b want 10", {d_gnt, if_gnt}); end
    n_vec++; if ({mem_addr, mem_we} !== {32'h100, 1'b0}) begin n_err++; $display("FAIL conflict_mem: got %h/%b want 00000100/0", mem_addr, mem_we); end
    n_vec++; if (dbg_owner !== 2'd2) begin n_err++; $display("FAIL conflict_owner: got %0d want 2", dbg_owner); end
    d_req = 1'b0;
    tick();  // N+2 = M
    mem_respond(32'h11112222);  // M+1
    n_vec++; if ({d_rvalid, if_rvalid, if_gnt} !== 3'b100) begin n_err++; $display("FAIL conflict_d_resp: got %b want 100", {d_rvalid, if_rvalid, if_gnt}); end
    n_vec++; if (d_rdata !== 32'h11112222) begin n_err++; $display("FAIL conflict_d_rdata: got %h want 11112222", d_rdata); end
    tick();  // M+2
    n_vec++; if ({if_gnt, d_gnt, mem_en} !== 3'b101) begin n_err++; $display("FAIL conflict_if_gnt: got %b want 101", {if_gnt, d_gnt, mem_en}); end
    n_vec++; if (mem_addr !== 32'h44) begin n_err++; $display("FAIL conflict_if_addr: got %h want 00000044", mem_addr); end
    if_req = 1'b0;
    tick();
    mem_respond(32'h33334444);
    n_vec++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h33334444}) begin n_err++; $display("FAIL conflict_if_resp: got %b/%h want 1/33334444", if_rvalid, if_rdata); end
    n_vec++; if (d_rdata !== 32'h11112222) begin n_err++; $display("FAIL conflict_d_rdata_hold: got %h want 11112222", d_rdata); end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_order [10];
    logic [1:0] got;
    int         waited;
    exp_order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    if_req  = 1'b1;
    if_addr = 32'h80;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h300;
    for (int g = 0; g < 10; g++) begin
      waited = 0;
      tick();
      while (!(if_gnt || d_gnt) && waited < 8) begin
        tick();
        waited++;
      end
      got = if_gnt ? 2'd1 : (d_gnt ? 2'd2 : 2'd0);
      n_vec++; if (got !== exp_order[g]) begin n_err++; $display("FAIL starve_order[%0d]: got %0d want %0d", g, got, exp_order[g]); end
      n_vec++; if ((if_gnt && d_gnt) || (waited != 0)) begin n_err++; $display("FAIL starve_timing[%0d]: gnt %b%b after %0d extra cycles want one gnt, 0", g, if_gnt, d_gnt, waited); end
      if (if_gnt) if_req = 1'b0;
      tick();
      mem_respond(32'hA0 + DW'(g));
    end
    d_req = 1'b0;
    n_vec++; if ({if_rdata, d_rdata} !== {32'hA4, 32'hA9}) begin n_err++; $display("FAIL starve_rdata: got %h/%h want 000000a4/000000a9", if_rdata, d_rdata); end
    tick();
  endtask

  task automatic test_store();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h200;
    d_wdata = 32'hDEADBEEF;
    tick();
    n_vec++; if ({d_gnt, mem_en, mem_we} !== 3'b111) begin n_err++; $display("FAIL store_gnt: got %b want 111", {d_gnt, mem_en, mem_we}); end
    n_vec++; if ({mem_addr, mem_wdata} !== {32'h200, 32'hDEADBEEF}) begin n_err++; $display("FAIL store_mem: got %h/%h want 00000200/deadbeef", mem_addr, mem_wdata); end
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    n_vec++; if ({mem_we, mem_wdata} !== {1'b1, 32'hDEADBEEF}) begin n_err++; $display("FAIL store_hold: got %b/%h want 1/deadbeef", mem_we, mem_wdata); end
    mem_respond(32'h5555);
    n_vec++; if ({d_rvalid, if_rvalid} !== 2'b10) begin n_err++; $display("FAIL store_ack: got %b want 10", {d_rvalid, if_rvalid}); end
    tick();
  endtask

  task automatic test_ack_ignored();
    // ack while IDLE
    mem_respond(32'hBAD0);
    n_vec++; if ({if_rvalid, d_rvalid, dbg_owner} !== 4'b0000) begin n_err++; $display("FAIL idle_ack: got %b want 0000", {if_rvalid, d_rvalid, dbg_owner}); end
    // ack in the mem_en cycle
    d_req  = 1'b1;
    d_addr = 32'h104;
    tick();  // mem_en cycle
    d_req = 1'b0;
    mem_respond(32'hBAD1);
    n_vec++; if ({d_rvalid, dbg_owner} !== {1'b0, 2'd2}) begin n_err++; $display("FAIL en_cycle_ack: got %b/%0d want 0/2", d_rvalid, dbg_owner); end
    mem_respond(32'h0000C0DE);
    n_vec++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h0000C0DE}) begin n_err++; $display("FAIL late_ack: got %b/%h want 1/0000c0de", d_rvalid, d_rdata); end
    tick();
  endtask

  task automatic test_timeout();
    int cyc;
    if_req  = 1'b1;
    if_addr = 32'h70;
    tick();  // mem_en cycle
    if_req = 1'b0;
    cyc = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    while (!if_rvalid && cyc < 40) begin
      tick();
      cyc++;
    end
    n_vec++; if (cyc != 17) begin n_err++; $display("FAIL timeout_latency: got %0d want 17", cyc); end
    n_vec++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL timeout_resp: got %b/%h want 1/00000000", if_rvalid, if_rdata); end
    n_vec++; if ({timeout_err, dbg_owner} !== {1'b1, 2'd0}) begin n_err++; $display("FAIL timeout_err_set: got %b/%0d want 1/0", timeout_err, dbg_owner); end
    repeat (5) tick();
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_err_sticky: got %b want 1", timeout_err); end
`else
    while (!if_rvalid && cyc < 30) begin
      tick();
      cyc++;
    end
    n_vec++; if ({if_rvalid, dbg_owner, timeout_err} !== {1'b0, 2'd1, 1'b0}) begin n_err++; $display("FAIL no_watchdog_wait: got %b/%0d/%b want 0/1/0", if_rvalid, dbg_owner, timeout_err); end
    mem_respond(32'h7777);
    n_vec++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h7777}) begin n_err++; $display("FAIL no_watchdog_resp: got %b/%h want 1/00007777", if_rvalid, if_rdata); end
`endif
    tick();
  endtask

  task automatic test_reset_busy();
    if_req  = 1'b1;
    if_addr = 32'h60;
    tick();
    if_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    n_vec++; if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, timeout_err, dbg_owner} !== 9'b0) begin n_err++; $display("FAIL rstbusy_ctrl: got %b want 0", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, timeout_err, dbg_owner}); end
    n_vec++; if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin n_err++; $display("FAIL rstbusy_data: got %h want 0", {if_rdata, d_rdata, mem_addr, mem_wdata}); end
    reset = 1'b1;
    mem_respond(32'hFEEDFACE);
    n_vec++; if ({if_rvalid, d_rvalid, dbg_owner} !== 4'b0) begin n_err++; $display("FAIL rstbusy_late_ack: got %b want 0000", {if_rvalid, d_rvalid, dbg_owner}); end
    d_req  = 1'b1;
    d_addr = 32'h120;
    tick();
    n_vec++; if ({d_gnt, mem_en, mem_addr} !== {2'b11, 32'h120}) begin n_err++; $display("FAIL rstbusy_next_gnt: got %b%b/%h want 11/00000120", d_gnt, mem_en, mem_addr); end
    d_req = 1'b0;
    tick();
    mem_respond(32'h12345678);
    n_vec++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h12345678}) begin n_err++; $display("FAIL rstbusy_next_resp: got %b/%h want 1/12345678", d_rvalid, d_rdata); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_starvation();
    test_store();
    test_ack_ignored();
    test_timeout();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single memory port between the instruction-fetch stage and the load/store stage. It accepts one request per requester, selects a winner, issues exactly one memory transaction at a time, and routes the response back to the owner. Data accesses have priority, with a starvation guard so fetch cannot be locked out. It sits between the pipeline front/back ends and the unified memory, inside `processor`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (1..15)
- `TIMEOUT_CYC`, 16, watchdog limit in cycles (only used with `MEM_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `if_req`  in  1  fetch request
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted (1-cycle pulse)
- `if_rvalid`  out  1  fetch response valid (1-cycle pulse)
- `if_rdata`  out  DATA_W  fetch data
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_gnt`  out  1  data accepted (pulse)
- `d_rvalid`  out  1  load data / store ack (pulse)
- `d_rdata`  out  DATA_W  load data
- `mem_en`  out  1  memory strobe (1-cycle pulse)
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_ack`  in  1  memory completion (any latency ≥1)
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ack`
- `dbg_owner`  out  2  0 = none, 1 = fetch, 2 = data
- `timeout_err`  out  1  sticky watchdog error

## Operation
- The FSM has two states: IDLE and BUSY.
  - IDLE → BUSY when `if_req | d_req` is sampled.
  - BUSY → IDLE on `mem_ack`, or on watchdog expiry.
- Arbitration, evaluated in IDLE only:
  - Fetch wins if `d_req` = 0.
  - Fetch also wins if `if_req` = 1 and `starve_cnt` == `STARVE_MAX`.
  - Otherwise data wins.
- `starve_cnt` (4-bit):
  - Increments on a data grant while `if_req` = 1.
  - Clears on a fetch grant, or on any grant with `if_req` = 0.
  - Saturates at `STARVE_MAX`.
- On grant, the winner's address, `we` and `wdata` are latched into `mem_*` and held through BUSY. Fetch grants force `mem_we` = 0.
- Requesters hold `req`, `addr` and `wdata` stable until `gnt`. A `req` still high after `gnt` is a new request, arbitrated when the FSM is next in IDLE.
- On `mem_ack`, `mem_rdata` is latched into the owner's `rdata` and the owner's `rvalid` pulses.
  - Stores also pulse `d_rvalid`; `d_rdata` then carries the latched value and is don't-care.
  - `rdata` holds until the next response to the same requester.
- `mem_ack` is ignored in IDLE and in the same cycle as `mem_en`.
- `dbg_owner` equals the current owner while BUSY and 0 in IDLE.

## Timing
- Reset (`reset` = 0 at an edge), from any state including BUSY:
  - State goes to IDLE.
  - All outputs, `starve_cnt` and watchdog clear to 0; `rdata` registers also clear.
  - A `mem_ack` for the aborted transaction is ignored.
- Cycle timeline:
  - N: `req` sampled in IDLE.
  - N+1: `gnt` = 1, `mem_en` = 1, state BUSY.
  - M ≥ N+2: `mem_ack`.
  - M+1: `rvalid` = 1, state IDLE, `req` sampled again.
  - M+2: next `gnt`/`mem_en`.
- Minimum 3 cycles per transaction (memory latency 1); arbitration latency is 1 cycle.
- Simultaneous `if_req` and `d_req`: exactly one `gnt` per cycle. The loser's `req` stays pending and is never dropped.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A 5-bit watchdog counts BUSY cycles, starting at the cycle after `mem_en`.
  - If the count reaches `TIMEOUT_CYC` without `mem_ack`, the FSM returns to IDLE and the owner's `rvalid` pulses with `rdata` = 0.
  - `timeout_err` is set and stays 1 until reset.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No watchdog; BUSY waits indefinitely.
  - `timeout_err` is tied to 0.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_BUSY`);
  - owner constants (`OWN_NONE` = 0, `OWN_IF` = 1, `OWN_D` = 2);
  - the default `STARVE_MAX`.
- Sub-module `mem_arb_watchdog` (counter plus sticky error) is instantiated only under `MEM_ARB_TIMEOUT_EN`.
- The rest of the block is a single module.

## Test plan
- Single fetch: `if_req` = 1, `if_addr` = 0x40, memory acks 2 cycles after `mem_en` with 0x2402000A → `if_gnt` at N+1, `mem_addr` = 0x40, `mem_we` = 0, `if_rvalid` with `if_rdata` = 0x2402000A at M+1, `dbg_owner` 1 → 0.
- Conflict: `if_req` and `d_req` (load 0x100) asserted in the same cycle → data granted first, fetch granted at M+2, no lost request.
- Starvation: `d_req` held high for 10 transactions with `if_req` high and `STARVE_MAX` = 4 → grant order D, D, D, D, IF, D, …
- Store: `d_we` = 1, `d_addr` = 0x200, `d_wdata` = 0xDEADBEEF → `mem_we` = 1 with those values, `d_rvalid` pulses, `if_rvalid` stays 0.
- Reset mid-BUSY: drop `reset` while awaiting `mem_ack`, then send a late `mem_ack` → no `rvalid`, all outputs 0, and the next request proceeds normally.
- With `MEM_ARB_TIMEOUT_EN` defined: never ack → `rvalid` pulses with `rdata` = 0 after 16 BUSY cycles, `timeout_err` = 1 and sticky.
